// File: rtl/execute_issue_ctrl_if.sv
// Handshake and operand bundle between decode, the issue controller, the ALU/MDU and writeback.
// The master side is decode/writeback; the slave side is the issue controller.
interface execute_issue_ctrl_if #(
  parameter int WORD_SIZE = 32
);
  logic                 id_valid;
  logic                 id_ready;
  logic [6:0]           id_funct7;
  logic [2:0]           id_funct3;
  logic [WORD_SIZE-1:0] id_src1;
  logic [WORD_SIZE-1:0] id_src2;
  logic [4:0]           id_rd;
  logic                 id_we;
  logic                 flush;
  logic [WORD_SIZE-1:0] ex_src1;
  logic [WORD_SIZE-1:0] ex_src2;
  logic [6:0]           ex_funct7;
  logic [2:0]           ex_funct3;
  logic [4:0]           ex_rd;
  logic                 ex_we;
  logic                 mdu_start;
  logic                 ex_valid;
  logic                 wb_ready;
  logic                 busy;

  modport master (
    output id_valid, id_funct7, id_funct3, id_src1, id_src2, id_rd, id_we, flush, wb_ready,
    input  id_ready, ex_src1, ex_src2, ex_funct7, ex_funct3, ex_rd, ex_we, mdu_start,
           ex_valid, busy
  );

  modport slave (
    input  id_valid, id_funct7, id_funct3, id_src1, id_src2, id_rd, id_we, flush, wb_ready,
    output id_ready, ex_src1, ex_src2, ex_funct7, ex_funct3, ex_rd, ex_we, mdu_start,
           ex_valid, busy
  );
endinterface

// File: rtl/execute_issue_ctrl.sv
// Issue controller in front of the execute stage: latches one decoded op per handshake, counts
// out multi-cycle MUL/DIV ops and holds the result for writeback under backpressure.
module execute_issue_ctrl #(
  parameter int WORD_SIZE   = 32,
  parameter int MUL_LATENCY = 3,
  parameter int DIV_LATENCY = 32
) (
  input logic                  clk,
  input logic                  rst,
  execute_issue_ctrl_if.slave  ctrl_if
);
  localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULTI = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 mdu_start_q, mdu_start_d;
  logic                 ex_valid_q, ex_valid_d;
  logic                 busy_q, busy_d;
  logic [WORD_SIZE-1:0] ex_src1_q, ex_src2_q;
  logic [6:0]           ex_funct7_q;
  logic [2:0]           ex_funct3_q;
  logic [4:0]           ex_rd_q;
  logic                 ex_we_q;

  logic                 ready_s;
  logic                 accept_s;
  logic                 is_mext_s;
  logic                 load_s;
  logic [CNT_W-1:0]     lat_s;

  // Ready is held low during reset and in the flush cycle so nothing is accepted then.
  always_comb begin
    ready_s   = !rst && !ctrl_if.flush &&
                ((state_q == ST_IDLE) || ((state_q == ST_DONE) && ctrl_if.wb_ready));
    accept_s  = ctrl_if.id_valid && ready_s;
    is_mext_s = (ctrl_if.id_funct7 == 7'b0000001);
    lat_s     = ctrl_if.id_funct3[2] ? CNT_W'(DIV_LATENCY - 1) : CNT_W'(MUL_LATENCY - 1);
  end

  // Next-state logic; an accept from DONE reloads on the same edge for back-to-back issue.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mdu_start_d = 1'b0;
    load_s      = 1'b0;
    if (ctrl_if.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            load_s = 1'b1;
            if (is_mext_s) begin
              state_d     = ST_MULTI;
              cnt_d       = lat_s;
              mdu_start_d = 1'b1;
            end else begin
              state_d = ST_DONE;
            end
          end else if ((state_q == ST_DONE) && !ctrl_if.wb_ready) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MULTI: begin
          if (cnt_q == '0) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    ex_valid_d = (state_d == ST_DONE);
    busy_d     = (state_d != ST_IDLE);
  end

  // State, counter and status flops; ex_* fields only move on an accepted op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mdu_start_q <= 1'b0;
      ex_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      ex_src1_q   <= '0;
      ex_src2_q   <= '0;
      ex_funct7_q <= 7'd0;
      ex_funct3_q <= 3'd0;
      ex_rd_q     <= 5'd0;
      ex_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mdu_start_q <= mdu_start_d;
      ex_valid_q  <= ex_valid_d;
      busy_q      <= busy_d;
      if (load_s) begin
        ex_src1_q   <= ctrl_if.id_src1;
        ex_src2_q   <= ctrl_if.id_src2;
        ex_funct7_q <= ctrl_if.id_funct7;
        ex_funct3_q <= ctrl_if.id_funct3;
        ex_rd_q     <= ctrl_if.id_rd;
        ex_we_q     <= ctrl_if.id_we;
      end
    end
  end

  assign ctrl_if.id_ready  = ready_s;
  assign ctrl_if.ex_src1   = ex_src1_q;
  assign ctrl_if.ex_src2   = ex_src2_q;
  assign ctrl_if.ex_funct7 = ex_funct7_q;
  assign ctrl_if.ex_funct3 = ex_funct3_q;
  assign ctrl_if.ex_rd     = ex_rd_q;
  assign ctrl_if.ex_we     = ex_we_q & ex_valid_q;
  assign ctrl_if.mdu_start = mdu_start_q;
  assign ctrl_if.ex_valid  = ex_valid_q;
  assign ctrl_if.busy      = busy_q;
endmodule

// File: tb/tb_execute_issue_ctrl.sv
// Directed bench for execute_issue_ctrl: a scoreboard records each accepted op and is drained
// whenever writeback consumes a result; directed checks cover timing, backpressure and flush.
module tb_execute_issue_ctrl;
  typedef struct packed {
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  exp_t sb_q[$];

  execute_issue_ctrl_if #(.WORD_SIZE(32)) bus ();

  execute_issue_ctrl #(
    .WORD_SIZE  (32),
    .MUL_LATENCY(3),
    .DIV_LATENCY(32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ctrl_if(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] s1,
                          input logic [31:0] s2, input logic [4:0] rd, input logic we);
    bus.id_valid  = 1'b1;
    bus.id_funct7 = f7;
    bus.id_funct3 = f3;
    bus.id_src1   = s1;
    bus.id_src2   = s2;
    bus.id_rd     = rd;
    bus.id_we     = we;
  endtask

  // Scoreboard: pop on writeback consumption first, then push the op handed over this cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ex_valid && bus.wb_ready) begin
        check("sb_pending", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_src1", 64'(bus.ex_src1), 64'(e.s1));
          check("sb_src2", 64'(bus.ex_src2), 64'(e.s2));
          check("sb_funct7", 64'(bus.ex_funct7), 64'(e.f7));
          check("sb_funct3", 64'(bus.ex_funct3), 64'(e.f3));
          check("sb_rd", 64'(bus.ex_rd), 64'(e.rd));
          check("sb_we", 64'(bus.ex_we), 64'(e.we));
        end
      end
      if (bus.id_valid && bus.id_ready) begin
        sb_q.push_back('{f7: bus.id_funct7, f3: bus.id_funct3, s1: bus.id_src1,
                         s2: bus.id_src2, rd: bus.id_rd, we: bus.id_we});
      end
    end
  end

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.id_valid  = 1'b0;
    bus.id_funct7 = 7'd0;
    bus.id_funct3 = 3'd0;
    bus.id_src1   = 32'd0;
    bus.id_src2   = 32'd0;
    bus.id_rd     = 5'd0;
    bus.id_we     = 1'b0;
    bus.flush     = 1'b0;
    bus.wb_ready  = 1'b0;

    // Reset state
    tick();
    #1;
    check("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_id_ready", 64'(bus.id_ready), 64'd0);
    check("rst_mdu_start", 64'(bus.mdu_start), 64'd0);
    check("rst_ex_rd", 64'(bus.ex_rd), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rel_id_ready", 64'(bus.id_ready), 64'd1);

    // Test 1: reset two cycles into a DIV
    drive_op(7'b0000001, 3'b100, 32'd100, 32'd7, 5'd9, 1'b1);
    tick();
    bus.id_valid = 1'b0;
    #1;
    check("div_mdu_start", 64'(bus.mdu_start), 64'd1);
    check("div_busy", 64'(bus.busy), 64'd1);
    check("div_id_ready", 64'(bus.id_ready), 64'd0);
    check("div_ex_rd", 64'(bus.ex_rd), 64'd9);
    tick();
    rst = 1'b1;
    #1;
    check("t1_ex_valid", 64'(bus.ex_valid), 64'd0);
    check("t1_busy", 64'(bus.busy), 64'd0);
    check("t1_mdu_start", 64'(bus.mdu_start), 64'd0);
    check("t1_ex_rd", 64'(bus.ex_rd), 64'd0);
    check("t1_id_ready", 64'(bus.id_ready), 64'd0);
    sb_q.delete();
    tick();
    rst = 1'b0;
    #1;
    check("t1_rel_id_ready", 64'(bus.id_ready), 64'd1);

    // Test 2: back-to-back ADD stream
    bus.wb_ready = 1'b1;
    drive_op(7'd0, 3'd0, 32'd5, 32'd7, 5'd3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) bus.id_valid = 1'b0;
      else bus.id_src1 = 32'd6 + 32'(i);
      #1;
      check("add_ex_valid", 64'(bus.ex_valid), 64'd1);
      check("add_ex_rd", 64'(bus.ex_rd), 64'd3);
      check("add_ex_we", 64'(bus.ex_we), 64'd1);
      check("add_ex_src1", 64'(bus.ex_src1), 64'd5 + 64'(i));
      if (i < 3) check("add_id_ready", 64'(bus.id_ready), 64'd1);
    end
    tick();
    #1;
    check("add_drain_valid", 64'(bus.ex_valid), 64'd0);
    check("add_drain_busy", 64'(bus.busy), 64'd0);

    // Test 3: MUL with latency 3
    drive_op(7'b0000001, 3'b000, 32'd6, 32'd9, 5'd4, 1'b1);
    tick();
    bus.id_valid = 1'b0;
    #1;
    check("mul_start_pulse", 64'(bus.mdu_start), 64'd1);
    check("mul_id_ready0", 64'(bus.id_ready), 64'd0);
    check("mul_ex_valid0", 64'(bus.ex_valid), 64'd0);
    tick();
    #1;
    check("mul_start_low", 64'(bus.mdu_start), 64'd0);
    check("mul_id_ready1", 64'(bus.id_ready), 64'd0);
    tick();
    #1;
    check("mul_id_ready2", 64'(bus.id_ready), 64'd0);
    check("mul_ex_valid2", 64'(bus.ex_valid), 64'd0);
    tick();
    #1;
    check("mul_ex_valid3", 64'(bus.ex_valid), 64'd1);
    check("mul_id_ready3", 64'(bus.id_ready), 64'd1);
    tick();
    #1;
    check("mul_drain_valid", 64'(bus.ex_valid), 64'd0);
    check("mul_drain_busy", 64'(bus.busy), 64'd0);

    // Test 4: DIV flushed at accept+10
    drive_op(7'b0000001, 3'b100, 32'd77, 32'd3, 5'd12, 1'b1);
    tick();
    bus.id_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("div_wait_valid", 64'(bus.ex_valid), 64'd0);
      check("div_wait_busy", 64'(bus.busy), 64'd1);
    end
    bus.flush = 1'b1;
    #1;
    check("flush_id_ready", 64'(bus.id_ready), 64'd0);
    tick();
    bus.flush = 1'b0;
    sb_q.delete();
    #1;
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_ex_valid", 64'(bus.ex_valid), 64'd0);
    check("flush_mdu_start", 64'(bus.mdu_start), 64'd0);
    check("flush_id_ready_after", 64'(bus.id_ready), 64'd1);
    for (int i = 0; i < 30; i++) begin
      tick();
      check("flush_no_valid", 64'(bus.ex_valid), 64'd0);
    end

    // Test 5: writeback backpressure then same-edge consume and accept
    bus.wb_ready = 1'b0;
    drive_op(7'd0, 3'b111, 32'h0000_F0F0, 32'h0000_0FF0, 5'd7, 1'b0);
    tick();
    drive_op(7'd0, 3'b001, 32'd11, 32'd22, 5'd8, 1'b1);
    #1;
    check("bp_ex_valid", 64'(bus.ex_valid), 64'd1);
    check("bp_ex_we", 64'(bus.ex_we), 64'd0);
    check("bp_id_ready", 64'(bus.id_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_src1", 64'(bus.ex_src1), 64'h0000_F0F0);
      check("bp_hold_funct3", 64'(bus.ex_funct3), 64'd7);
      check("bp_hold_rd", 64'(bus.ex_rd), 64'd7);
      check("bp_hold_valid", 64'(bus.ex_valid), 64'd1);
      check("bp_hold_ready", 64'(bus.id_ready), 64'd0);
    end
    bus.wb_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus.id_ready), 64'd1);
    tick();
    bus.id_valid = 1'b0;
    #1;
    check("b2b_ex_rd", 64'(bus.ex_rd), 64'd8);
    check("b2b_ex_src1", 64'(bus.ex_src1), 64'd11);
    check("b2b_ex_valid", 64'(bus.ex_valid), 64'd1);
    check("b2b_ex_we", 64'(bus.ex_we), 64'd1);
    tick();
    #1;
    check("b2b_drain_valid", 64'(bus.ex_valid), 64'd0);
    check("b2b_drain_busy", 64'(bus.busy), 64'd0);

    // Test 6: flush with id_valid in IDLE
    bus.flush = 1'b1;
    drive_op(7'd0, 3'd0, 32'h0000_DEAD, 32'd1, 5'd15, 1'b1);
    #1;
    check("fi_id_ready", 64'(bus.id_ready), 64'd0);
    tick();
    bus.flush    = 1'b0;
    bus.id_valid = 1'b0;
    #1;
    check("fi_busy", 64'(bus.busy), 64'd0);
    check("fi_ex_valid", 64'(bus.ex_valid), 64'd0);
    check("fi_ex_rd", 64'(bus.ex_rd), 64'd8);
    check("fi_ex_src1", 64'(bus.ex_src1), 64'd11);
    tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
